mem_access_ctrl: RTL

//  Memory-side stage directly upstream of the MDR. Takes read/write commands

---
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// RAM-side request/ready bus between mem_access_ctrl (master) and the memory (slave).
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access stage upstream of the MDR: req/ready handshake to RAM, read data capture.
// Optional request timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  mar_q,
  input  logic [DATA_W-1:0]  mdr_q,
  mem_access_ctrl_if.master  mem,
  output logic [DATA_W-1:0]  rdata,
  output logic               mdr_load,
  output logic               busy,
  output logic               done,
  output logic               cmd_err,
  output logic               tmo_err
);

  localparam int unsigned CNT_MAX = (TIMEOUT > 15) ? TIMEOUT : 15;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            r_state,    w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,    w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata,    w_rdata_nxt;
  logic              r_we,       w_we_nxt;
  logic              r_req,      w_req_nxt;
  logic              r_mdr_load, w_mdr_load_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_cmd_err,  w_cmd_err_nxt;
  logic              r_tmo_err,  w_tmo_err_nxt;
  logic              w_accept;
  logic              w_timeout;

  assign w_accept = mem.mem_ready && (r_wait_cnt >= CNT_W'(MIN_WAIT));

`ifdef MEM_TIMEOUT_EN
  // Last allowed REQ cycle; a same-cycle accept takes priority over the abort
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_we_nxt       = r_we;
    w_req_nxt      = r_req;
    w_mdr_load_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_cmd_err_nxt  = 1'b0;
    w_tmo_err_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (rd ^ wr) begin
          w_addr_nxt     = mar_q;
          w_wdata_nxt    = mdr_q;
          w_we_nxt       = wr;
          w_req_nxt      = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = REQ;
        end else if (rd && wr) begin
          w_cmd_err_nxt  = 1'b1;
        end
      end
      REQ: begin
        w_cmd_err_nxt = rd | wr;
        if (w_accept) begin
          w_req_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
          if (!r_we) begin
            w_rdata_nxt    = mem.mem_rdata;
            w_mdr_load_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_req_nxt     = 1'b0;
          w_done_nxt    = 1'b1;
          w_tmo_err_nxt = 1'b1;
          w_state_nxt   = DONE;
        end else if (r_wait_cnt != '1) begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_cmd_err_nxt = rd | wr;
        w_state_nxt   = IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_req      <= 1'b0;
      r_mdr_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_we       <= w_we_nxt;
      r_req      <= w_req_nxt;
      r_mdr_load <= w_mdr_load_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_cmd_err  <= w_cmd_err_nxt;
      r_tmo_err  <= w_tmo_err_nxt;
    end
  end

  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_we    = r_we;
  assign mem.mem_req   = r_req;
  assign rdata         = r_rdata;
  assign mdr_load      = r_mdr_load;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cmd_err       = r_cmd_err;
  assign tmo_err       = r_tmo_err;

endmodule
